// File: rtl/mem_write_checker_pkg.sv
// Shared types for the memory-write self-check monitor.
package mem_write_checker_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} state_t;
  typedef enum logic [1:0] {FC_NONE, FC_DATA, FC_ADDR, FC_TIMEOUT} fail_code_t;

  localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/mwc_expect_table.sv
// Expected-write table: one cfg write port, one combinational read port.
module mwc_expect_table #(
  parameter int unsigned N_EXPECT = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IDX_W    = 2
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_wrEn,
  input  logic [IDX_W-1:0]  i_wrIdx,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic [IDX_W-1:0]  i_rdIdx,
  output logic [ADDR_W-1:0] o_rdAddr_c,
  output logic [DATA_W-1:0] o_rdData_c
);

  logic [ADDR_W-1:0] addrMem [N_EXPECT];
  logic [DATA_W-1:0] dataMem [N_EXPECT];

  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < N_EXPECT; i++) begin
      if (i_srst) begin
        addrMem[i] <= '0;
        dataMem[i] <= '0;
      end else if (i_wrEn && (i_wrIdx == IDX_W'(i))) begin
        addrMem[i] <= i_wrAddr;
        dataMem[i] <= i_wrData;
      end
    end
  end

  // Out-of-range indices read as zero.
  always_comb begin
    o_rdAddr_c = '0;
    o_rdData_c = '0;
    for (int unsigned i = 0; i < N_EXPECT; i++) begin
      if (i_rdIdx == IDX_W'(i)) begin
        o_rdAddr_c = addrMem[i];
        o_rdData_c = dataMem[i];
      end
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Self-check monitor for a tapped data-memory write port: ordered expected-write table,
// cycle timeout, pass/fail/cause outputs. Define MWC_STROBE_EN to add byte-strobe compare.
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned N_EXPECT       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          STRICT         = 1'b0,
  localparam int unsigned IDX_W  = (N_EXPECT > 1) ? $clog2(N_EXPECT) : 1,
  localparam int unsigned CNT_W  = $clog2(N_EXPECT + 1),
  localparam int unsigned CYC_W  = $clog2(TIMEOUT_CYCLES + 1),
  localparam int unsigned STRB_W = DATA_W / BYTE_W
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_cfgValid,
  input  logic [IDX_W-1:0]  i_cfgIdx,
  input  logic [ADDR_W-1:0] i_cfgAddr,
  input  logic [DATA_W-1:0] i_cfgData,
  input  logic [CNT_W-1:0]  i_cfgCount,
  input  logic              i_start,
  input  logic              i_writeEnable,
  input  logic [ADDR_W-1:0] i_rwAddress,
  input  logic [DATA_W-1:0] i_writeData,
`ifdef MWC_STROBE_EN
  input  logic [STRB_W-1:0] i_writeStrobe,
`endif
  output logic              o_done,
  output logic              o_pass,
  output logic              o_fail,
  output logic [1:0]        o_failCode,
  output logic [CNT_W-1:0]  o_matchCount,
  output logic [CYC_W-1:0]  o_cycleCount
);

  state_t           state;
  fail_code_t       failCode;
  logic [CNT_W-1:0] activeCount;
  logic [CNT_W-1:0] matchCount;
  logic [CYC_W-1:0] cycleCount;

  logic [ADDR_W-1:0] expAddr_c;
  logic [DATA_W-1:0] expData_c;
  logic [STRB_W-1:0] strobe_c;
  logic [DATA_W-1:0] byteMask_c;
  logic              wrValid_c;
  logic              addrHit_c;
  logic              dataHit_c;
  logic              matchHit_c;
  logic              lastMatch_c;
  logic              dataErr_c;
  logic              addrErr_c;
  logic              timeoutHit_c;
  logic [CNT_W-1:0]  cfgCountClamped_c;
  logic [CYC_W-1:0]  cycleNext_c;

  // Table is frozen while a check is running.
  mwc_expect_table #(
    .N_EXPECT (N_EXPECT),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) u_table (
    .i_clk      (i_clk),
    .i_srst     (i_srst),
    .i_wrEn     (i_cfgValid && (state != ARMED)),
    .i_wrIdx    (i_cfgIdx),
    .i_wrAddr   (i_cfgAddr),
    .i_wrData   (i_cfgData),
    .i_rdIdx    (IDX_W'(matchCount)),
    .o_rdAddr_c (expAddr_c),
    .o_rdData_c (expData_c)
  );

`ifdef MWC_STROBE_EN
  assign strobe_c = i_writeStrobe;
`else
  assign strobe_c = '1;
`endif

  always_comb begin
    byteMask_c = '0;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      byteMask_c[b*BYTE_W +: BYTE_W] = {BYTE_W{strobe_c[b]}};
    end
  end

  // An all-zero strobe is not a write.
  assign wrValid_c    = i_writeEnable && (|strobe_c);
  assign addrHit_c    = (i_rwAddress == expAddr_c);
  assign dataHit_c    = (((i_writeData ^ expData_c) & byteMask_c) == '0);
  assign matchHit_c   = wrValid_c && addrHit_c && dataHit_c;
  assign lastMatch_c  = ((matchCount + CNT_W'(1)) == activeCount);
  assign dataErr_c    = wrValid_c && addrHit_c && !dataHit_c;
  assign addrErr_c    = STRICT && wrValid_c && !addrHit_c;
  assign cycleNext_c  = (cycleCount == CYC_W'(TIMEOUT_CYCLES)) ? cycleCount
                                                               : cycleCount + CYC_W'(1);
  assign timeoutHit_c = (cycleNext_c == CYC_W'(TIMEOUT_CYCLES));
  assign cfgCountClamped_c = (i_cfgCount > CNT_W'(N_EXPECT)) ? CNT_W'(N_EXPECT) : i_cfgCount;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state       <= IDLE;
      failCode    <= FC_NONE;
      activeCount <= '0;
      matchCount  <= '0;
      cycleCount  <= '0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_fail      <= 1'b0;
    end else begin
      case (state)
        ARMED: begin
          cycleCount <= cycleNext_c;
          if (matchHit_c) begin
            matchCount <= matchCount + CNT_W'(1);
          end
          // Final match beats a same-cycle timeout.
          if (matchHit_c && lastMatch_c) begin
            state  <= PASS;
            o_done <= 1'b1;
            o_pass <= 1'b1;
          end else if (dataErr_c) begin
            state    <= FAIL;
            failCode <= FC_DATA;
            o_done   <= 1'b1;
            o_fail   <= 1'b1;
          end else if (addrErr_c) begin
            state    <= FAIL;
            failCode <= FC_ADDR;
            o_done   <= 1'b1;
            o_fail   <= 1'b1;
          end else if (timeoutHit_c) begin
            state    <= FAIL;
            failCode <= FC_TIMEOUT;
            o_done   <= 1'b1;
            o_fail   <= 1'b1;
          end
        end
        default: begin
          if (i_start) begin
            activeCount <= cfgCountClamped_c;
            matchCount  <= '0;
            cycleCount  <= '0;
            failCode    <= FC_NONE;
            o_fail      <= 1'b0;
            if (cfgCountClamped_c == '0) begin
              state  <= PASS;
              o_done <= 1'b1;
              o_pass <= 1'b1;
            end else begin
              state  <= ARMED;
              o_done <= 1'b0;
              o_pass <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign o_failCode   = failCode;
  assign o_matchCount = matchCount;
  assign o_cycleCount = cycleCount;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: loose and strict instances share stimulus and are
// compared against a write-list outcome model.
module tb_mem_write_checker;

  localparam int NE   = 4;
  localparam int TO   = 16;
  localparam int NCYC = TO + 2;

  logic        clk;
  logic        srst;
  logic        cfgValid;
  logic [1:0]  cfgIdx;
  logic [31:0] cfgAddr;
  logic [31:0] cfgData;
  logic [2:0]  cfgCount;
  logic        start;
  logic        writeEnable;
  logic [31:0] rwAddress;
  logic [31:0] writeData;
`ifdef MWC_STROBE_EN
  logic [3:0]  writeStrobe;
`endif

  logic        done       [2];
  logic        pass       [2];
  logic        fail       [2];
  logic [1:0]  failCode   [2];
  logic [2:0]  matchCount [2];
  logic [4:0]  cycleCount [2];

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .N_EXPECT(NE), .TIMEOUT_CYCLES(TO), .STRICT(1'b0)
  ) dutLoose (
    .i_clk(clk), .i_srst(srst), .i_cfgValid(cfgValid), .i_cfgIdx(cfgIdx),
    .i_cfgAddr(cfgAddr), .i_cfgData(cfgData), .i_cfgCount(cfgCount), .i_start(start),
    .i_writeEnable(writeEnable), .i_rwAddress(rwAddress), .i_writeData(writeData),
`ifdef MWC_STROBE_EN
    .i_writeStrobe(writeStrobe),
`endif
    .o_done(done[0]), .o_pass(pass[0]), .o_fail(fail[0]), .o_failCode(failCode[0]),
    .o_matchCount(matchCount[0]), .o_cycleCount(cycleCount[0])
  );

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .N_EXPECT(NE), .TIMEOUT_CYCLES(TO), .STRICT(1'b1)
  ) dutStrict (
    .i_clk(clk), .i_srst(srst), .i_cfgValid(cfgValid), .i_cfgIdx(cfgIdx),
    .i_cfgAddr(cfgAddr), .i_cfgData(cfgData), .i_cfgCount(cfgCount), .i_start(start),
    .i_writeEnable(writeEnable), .i_rwAddress(rwAddress), .i_writeData(writeData),
`ifdef MWC_STROBE_EN
    .i_writeStrobe(writeStrobe),
`endif
    .o_done(done[1]), .o_pass(pass[1]), .o_fail(fail[1]), .o_failCode(failCode[1]),
    .o_matchCount(matchCount[1]), .o_cycleCount(cycleCount[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference table and per-run write list (index = armed cycle number).
  logic [31:0] tA  [NE];
  logic [31:0] tD  [NE];
  bit          wEn [NCYC+1];
  logic [31:0] wA  [NCYC+1];
  logic [31:0] wD  [NCYC+1];
  logic [3:0]  wS  [NCYC+1];
  bit          stP [NCYC+1];
  bit          cfN [NCYC+1];

  // Predicted outcome per instance: deciding cycle, verdict, cause, matches after each cycle.
  int dcX   [2];
  bit pX    [2];
  int codeX [2];
  int mcX   [2][NCYC+1];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] maskOf(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    start = 1'b0; cfgValid = 1'b0; cfgIdx = '0; cfgAddr = '0; cfgData = '0;
    writeEnable = 1'b0; rwAddress = '0; writeData = '0;
`ifdef MWC_STROBE_EN
    writeStrobe = '0;
`endif
  endtask

  task automatic clearStim();
    for (int k = 0; k <= NCYC; k++) begin
      wEn[k] = 1'b0; wA[k] = '0; wD[k] = '0; wS[k] = 4'hF; stP[k] = 1'b0; cfN[k] = 1'b0;
    end
  endtask

  task automatic setWrite(input int k, input logic [31:0] a, input logic [31:0] d);
    wEn[k] = 1'b1; wA[k] = a; wD[k] = d; wS[k] = 4'hF;
  endtask

  task automatic loadEntry(input int idx, input logic [31:0] a, input logic [31:0] d);
    cfgValid = 1'b1; cfgIdx = 2'(idx); cfgAddr = a; cfgData = d;
    tick();
    cfgValid = 1'b0;
    tA[idx] = a; tD[idx] = d;
  endtask

  task automatic clearModelTable();
    for (int i = 0; i < NE; i++) begin tA[i] = '0; tD[i] = '0; end
  endtask

  // Walk the write list in order; the first deciding event fixes the outcome.
  task automatic predict(input int u, input int active);
    int m;
    m = 0; dcX[u] = -1; pX[u] = 1'b0; codeX[u] = 0; mcX[u][0] = 0;
    if (active == 0) begin dcX[u] = 0; pX[u] = 1'b1; end
    for (int k = 1; k <= NCYC; k++) begin
      if (dcX[u] < 0) begin
        if (wEn[k] && (wS[k] != 4'h0)) begin
          if (wA[k] == tA[m]) begin
            if (((wD[k] ^ tD[m]) & maskOf(wS[k])) == 32'h0) begin
              m++;
              if (m == active) begin dcX[u] = k; pX[u] = 1'b1; end
            end else begin
              dcX[u] = k; codeX[u] = 1;
            end
          end else if (u == 1) begin
            dcX[u] = k; codeX[u] = 2;
          end
        end
        if ((dcX[u] < 0) && (k == TO)) begin dcX[u] = k; codeX[u] = 3; end
      end
      mcX[u][k] = m;
    end
  endtask

  function automatic string tg(input int run, input int k, input int u, input string nm);
    return $sformatf("run%0d cyc%0d %s %s", run, k, (u == 1) ? "strict" : "loose", nm);
  endfunction

  task automatic checkAt(input int run, input int k);
    bit dec;
    int expCode;
    for (int u = 0; u < 2; u++) begin
      dec     = (k >= dcX[u]);
      expCode = (dec && !pX[u]) ? codeX[u] : 0;
      checkEq(tg(run, k, u, "done"),  32'(done[u]),       32'(dec));
      checkEq(tg(run, k, u, "pass"),  32'(pass[u]),       32'(dec && pX[u]));
      checkEq(tg(run, k, u, "fail"),  32'(fail[u]),       32'(dec && !pX[u]));
      checkEq(tg(run, k, u, "code"),  32'(failCode[u]),   32'(expCode));
      checkEq(tg(run, k, u, "match"), 32'(matchCount[u]), 32'(mcX[u][k]));
      checkEq(tg(run, k, u, "cycle"), 32'(cycleCount[u]), 32'(dec ? dcX[u] : k));
    end
  endtask

  task automatic checkZero(input string tag);
    for (int u = 0; u < 2; u++) begin
      checkEq({tag, (u == 1) ? " strict done" : " loose done"},  32'(done[u]),       32'h0);
      checkEq({tag, (u == 1) ? " strict pass" : " loose pass"},  32'(pass[u]),       32'h0);
      checkEq({tag, (u == 1) ? " strict fail" : " loose fail"},  32'(fail[u]),       32'h0);
      checkEq({tag, (u == 1) ? " strict code" : " loose code"},  32'(failCode[u]),   32'h0);
      checkEq({tag, (u == 1) ? " strict match" : " loose match"}, 32'(matchCount[u]), 32'h0);
      checkEq({tag, (u == 1) ? " strict cycle" : " loose cycle"}, 32'(cycleCount[u]), 32'h0);
    end
  endtask

  // Start with a raw count, then play the write list; optional reset aborts at resetAt.
  task automatic runCase(input int run, input int raw, input int resetAt);
    int active;
    int gate;
    active = (raw > NE) ? NE : raw;
    predict(0, active);
    predict(1, active);
    gate = (dcX[0] < dcX[1]) ? dcX[0] : dcX[1];
    cfgCount = 3'(raw); start = 1'b1;
    tick();
    start = 1'b0; cfgCount = 3'($urandom);
    checkAt(run, 0);
    for (int k = 1; k <= NCYC; k++) begin
      if (k == resetAt) begin
        idleInputs();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        checkZero($sformatf("run%0d srst", run));
        clearModelTable();
        return;
      end
      writeEnable = wEn[k]; rwAddress = wA[k]; writeData = wD[k];
`ifdef MWC_STROBE_EN
      writeStrobe = wS[k];
`endif
      start    = stP[k] && (k <= gate);
      cfgValid = cfN[k] && (k <= gate);
      cfgIdx = 2'($urandom); cfgAddr = $urandom; cfgData = $urandom;
      tick();
      checkAt(run, k);
    end
    idleInputs();
  endtask

  initial begin
    int run;
    run = 0;
    srst = 1'b1; cfgCount = '0;
    idleInputs();
    clearModelTable();
    tick(); tick();
    srst = 1'b0;
    checkZero("reset");

    // Cleared table: a single (0,0) write satisfies one active entry.
    clearStim(); setWrite(1, 32'd0, 32'd0);
    runCase(run++, 1, 0);

    // Two-entry in-order pass, then data mismatch on the second entry.
    loadEntry(0, 32'd96, 32'd7); loadEntry(1, 32'd100, 32'd25);
    clearStim(); setWrite(1, 32'd96, 32'd7); setWrite(2, 32'd100, 32'd25);
    runCase(run++, 2, 0);
    clearStim(); setWrite(1, 32'd96, 32'd7); setWrite(2, 32'd100, 32'd24);
    runCase(run++, 2, 0);
    // Later entry's address seen early: ignored (loose) or fatal (strict).
    clearStim(); setWrite(1, 32'd100, 32'd25); setWrite(3, 32'd96, 32'd7); setWrite(5, 32'd100, 32'd25);
    runCase(run++, 2, 0);

    // Unexpected address, no writes (timeout), final match on the timeout cycle.
    loadEntry(0, 32'd100, 32'd25);
    clearStim(); setWrite(1, 32'd96, 32'd7);
    runCase(run++, 1, 0);
    clearStim();
    runCase(run++, 1, 0);
    clearStim(); setWrite(TO, 32'd100, 32'd25);
    runCase(run++, 1, 0);

    // Zero active entries and a clamped over-range count.
    clearStim();
    runCase(run++, 0, 0);
    for (int i = 0; i < NE; i++) loadEntry(i, 32'(8 * i), 32'(i + 1));
    clearStim();
    for (int i = 0; i < NE; i++) setWrite(2 * i + 1, 32'(8 * i), 32'(i + 1));
    runCase(run++, 7, 0);

    // Reset after one match, then reload and a clean pass.
    loadEntry(0, 32'd96, 32'd7); loadEntry(1, 32'd100, 32'd25);
    clearStim(); setWrite(1, 32'd96, 32'd7); setWrite(4, 32'd100, 32'd25);
    runCase(run++, 2, 3);
    loadEntry(0, 32'd96, 32'd7); loadEntry(1, 32'd100, 32'd25);
    clearStim(); setWrite(1, 32'd96, 32'd7); setWrite(2, 32'd100, 32'd25);
    runCase(run++, 2, 0);

`ifdef MWC_STROBE_EN
    loadEntry(0, 32'd100, 32'h19);
    clearStim(); setWrite(1, 32'd100, 32'hFFFFFF19); wS[1] = 4'b0001;
    runCase(run++, 1, 0);
    clearStim(); setWrite(1, 32'd100, 32'h19); wS[1] = 4'b0000;
    setWrite(2, 32'd100, 32'hAB000019); wS[2] = 4'b0011;
    runCase(run++, 1, 0);
`endif

    // Randomized runs: in-order "good" sequences with noise, or free-form writes.
    for (int r = 0; r < 48; r++) begin
      int mode;
      int k;
      int raw;
      int rstAt;
      if ($urandom_range(0, 2) == 0)
        for (int i = 0; i < NE; i++)
          loadEntry(i, 32'(4 * $urandom_range(0, 7)), 32'($urandom_range(0, 3)));
      clearStim();
      mode = int'($urandom_range(0, 1));
      if (mode == 0) begin
        k = 0;
        for (int e = 0; e < NE; e++) begin
          k += int'($urandom_range(1, 4));
          setWrite(k, tA[e], tD[e]);
`ifdef MWC_STROBE_EN
          wS[k] = 4'($urandom_range(1, 15));
          wD[k] = tD[e] ^ ($urandom & ~maskOf(wS[k]));
`endif
        end
        for (int c = 1; c <= NCYC; c++)
          if (!wEn[c] && ($urandom_range(0, 9) < 3))
            setWrite(c, 32'h200 + 32'(4 * $urandom_range(0, 7)), $urandom);
      end else begin
        for (int c = 1; c <= NCYC; c++) begin
          if ($urandom_range(0, 9) < 6) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'(4 * $urandom_range(0, 7));
            d = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7)
              for (int j = NE - 1; j >= 0; j--) if (tA[j] == a) d = tD[j];
            setWrite(c, a, d);
`ifdef MWC_STROBE_EN
            wS[c] = 4'($urandom_range(0, 15));
`endif
          end
        end
      end
      for (int c = 1; c <= NCYC; c++) begin
        stP[c] = ($urandom_range(0, 9) == 0);
        cfN[c] = ($urandom_range(0, 9) == 0);
      end
      raw   = int'($urandom_range(0, 7));
      rstAt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 0;
      runCase(run++, raw, rstAt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
